// File: rtl/g15_timing_pkg.sv
// Shared types and constants for the G-15 drum bit/word timing chain.
package g15_timing_pkg;

    localparam int unsigned BITS_PER_WORD = 29;
    localparam int unsigned WORDS_PER_REV = 108;
    localparam int unsigned BIT_W         = 5;
    localparam int unsigned WORD_W        = 7;

    typedef logic [BIT_W-1:0]  bit_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {TS_HALT, TS_RUN, TS_STEP} timing_state_t;

    // Bit time that follows b; bit times run 1..BITS_PER_WORD.
    function automatic bit_t next_bit(input bit_t b);
        return (b == bit_t'(BITS_PER_WORD)) ? bit_t'(1) : b + bit_t'(1);
    endfunction

    // Word that follows w; words run 0..WORDS_PER_REV-1.
    function automatic word_t next_word(input word_t w);
        return (w == word_t'(WORDS_PER_REV - 1)) ? word_t'(0) : w + word_t'(1);
    endfunction

endpackage

// File: rtl/bit_divider.sv
// CLOCK prescaler producing one ce strobe every DIV enabled cycles.
module bit_divider #(
    parameter int unsigned DIV = 4
) (
    input  logic CLOCK,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic ce
);

    localparam int unsigned CW   = $clog2(DIV) + 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + CW'(1);
        end
    end

    assign ce = en & (count == LAST);

endmodule

// File: rtl/drum_timing_gen.sv
// Drum bit-time / word-time sequencer with run, halt-at-word-boundary and step.
// Optional single-step support is enabled by defining G15_TIMING_STEP_EN.
module drum_timing_gen
    import g15_timing_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic       CLOCK,
    input  logic       rst,
    input  logic       RUN,
    input  logic       STEP,
    output logic       BIT_CE,
    output logic [4:0] BIT,
    output logic [6:0] WORD,
    output logic       T0,
    output logic       T1,
    output logic       T2,
    output logic       T13,
    output logic       T21,
    output logic       T28,
    output logic       T29,
    output logic       TF,
    output logic       EVEN,
    output logic       HALTED
);

    timing_state_t state, state_nx;
    bit_t          bit_q;
    word_t         word_q;
    bit_t          bit_nx_c;
    logic          stop_pend;
    logic          div_en, div_clr, div_ce;
    logic          bit_ce_c;
    logic          t29_c;

`ifndef G15_TIMING_STEP_EN
    logic unused_step;
    assign unused_step = STEP;
`endif

    bit_divider #(.DIV(DIV)) u_div (
        .CLOCK (CLOCK),
        .rst   (rst),
        .en    (div_en),
        .clr   (div_clr),
        .ce    (div_ce)
    );

    assign bit_nx_c = next_bit(bit_q);
    assign t29_c    = bit_ce_c & (bit_nx_c == bit_t'(29));

    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            state <= TS_HALT;
        end else begin
            state <= state_nx;
        end
    end

    // Stop requests are only honoured on the strobe that enters T29.
    always_comb begin
        state_nx = state;
        div_en   = 1'b0;
        div_clr  = 1'b1;
        bit_ce_c = 1'b0;
        unique case (state)
            TS_HALT: begin
                if (RUN) begin
                    state_nx = TS_RUN;
                end
`ifdef G15_TIMING_STEP_EN
                else if (STEP) begin
                    state_nx = TS_STEP;
                end
`endif
            end
            TS_RUN: begin
                div_en   = 1'b1;
                div_clr  = 1'b0;
                bit_ce_c = div_ce;
                if (div_ce && (bit_nx_c == bit_t'(29)) && stop_pend) begin
                    state_nx = TS_HALT;
                end
            end
`ifdef G15_TIMING_STEP_EN
            TS_STEP: begin
                bit_ce_c = 1'b1;
                state_nx = TS_HALT;
            end
`endif
            default: begin
                state_nx = TS_HALT;
            end
        endcase
    end

    // Pending stop tracks the latest sampled RUN level while running.
    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            stop_pend <= 1'b0;
        end else if (state == TS_RUN) begin
            stop_pend <= ~RUN;
        end else begin
            stop_pend <= 1'b0;
        end
    end

    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            bit_q  <= bit_t'(BITS_PER_WORD);
            word_q <= word_t'(WORDS_PER_REV - 1);
        end else if (bit_ce_c) begin
            bit_q <= bit_nx_c;
            if (bit_q == bit_t'(BITS_PER_WORD)) begin
                word_q <= next_word(word_q);
            end
        end
    end

    assign BIT_CE = bit_ce_c;
    assign BIT    = bit_q;
    assign WORD   = word_q;
    assign T1     = bit_ce_c & (bit_nx_c == bit_t'(1));
    assign T2     = bit_ce_c & (bit_nx_c == bit_t'(2));
    assign T13    = bit_ce_c & (bit_nx_c == bit_t'(13));
    assign T21    = bit_ce_c & (bit_nx_c == bit_t'(21));
    assign T28    = bit_ce_c & (bit_nx_c == bit_t'(28));
    assign T29    = t29_c;
    assign T0     = t29_c & (word_q == word_t'(WORDS_PER_REV - 1));
    assign TF     = t29_c & (word_q[1:0] == 2'b11);
    assign EVEN   = ~word_q[0];
    assign HALTED = (state == TS_HALT);

endmodule

// File: tb/tb_drum_timing_gen.sv
// Directed self-checking bench for drum_timing_gen (DIV=4 and DIV=1 instances).
module tb_drum_timing_gen;

`ifdef G15_TIMING_STEP_EN
    localparam int unsigned B_STEP = 3;
    localparam int unsigned B_RUN1 = 4;
`else
    localparam int unsigned B_STEP = 29;
    localparam int unsigned B_RUN1 = 1;
`endif

    logic       clk = 1'b0;
    logic       rst, run, step;
    logic       rst1, run1, step1;
    logic       ce, t0, t1, t2, t13, t21, t28, t29, tf, even, halted;
    logic [4:0] bt;
    logic [6:0] wd;
    logic       ce1, t0_1, t1_1, t2_1, t13_1, t21_1, t28_1, t29_1, tf_1, even1, halted1;
    logic [4:0] bt1;
    logic [6:0] wd1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    drum_timing_gen #(.DIV(4)) dut (
        .CLOCK(clk), .rst(rst), .RUN(run), .STEP(step),
        .BIT_CE(ce), .BIT(bt), .WORD(wd),
        .T0(t0), .T1(t1), .T2(t2), .T13(t13), .T21(t21), .T28(t28), .T29(t29),
        .TF(tf), .EVEN(even), .HALTED(halted)
    );

    drum_timing_gen #(.DIV(1)) dut1 (
        .CLOCK(clk), .rst(rst1), .RUN(run1), .STEP(step1),
        .BIT_CE(ce1), .BIT(bt1), .WORD(wd1),
        .T0(t0_1), .T1(t1_1), .T2(t2_1), .T13(t13_1), .T21(t21_1), .T28(t28_1), .T29(t29_1),
        .TF(tf_1), .EVEN(even1), .HALTED(halted1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic tany();
        return t0 | t1 | t2 | t13 | t21 | t28 | t29 | tf;
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, s, cyc, tfc, badtf, low, i13, i21, i28, w;
        logic found, last29, seen_halt, c, k1, h;

        rst = 1'b1; run = 1'b0; step = 1'b0;
        rst1 = 1'b1; run1 = 1'b0; step1 = 1'b0;
        repeat (3) tick();
        check("rst_halted", halted, 1);
        check("rst_bit", bt, 29);
        check("rst_word", wd, 107);
        check("rst_ce", ce, 0);
        check("rst_even", even, 0);
        check("rst_tpulse", tany(), 0);

        rst = 1'b0; rst1 = 1'b0;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (ce) n++;
        end
        check("idle_ce_count", n, 0);
        check("idle_halted", halted, 1);
        check("idle_bit", bt, 29);
        check("idle_word", wd, 107);

        // Free run: first strobe DIV cycles after RUN is sampled.
        run = 1'b1;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (ce) begin n = i; break; end
        end
        check("first_ce_cycle", n, 4);
        check("first_t1", t1, 1);
        check("first_t0", t0, 0);
        tick();
        check("first_bit", bt, 1);
        check("first_word", wd, 0);
        check("first_even", even, 1);

        s = 1; found = 0; i13 = 0; i21 = 0; i28 = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (ce) begin
                s++;
                if (t13) i13 = s;
                if (t21) i21 = s;
                if (t28) i28 = s;
                if (t29) begin found = 1; break; end
            end
        end
        check("t29_found", found, 1);
        check("t29_strobe_idx", s, 29);
        check("t13_strobe_idx", i13, 13);
        check("t21_strobe_idx", i21, 21);
        check("t28_strobe_idx", i28, 28);
        check("t29_word0_tf", tf, 0);
        check("t29_word0_t0", t0, 0);

        found = 0;
        for (int i = 0; i < 13000; i++) begin
            tick();
            if (t0) begin found = 1; break; end
        end
        check("t0_found", found, 1);
        check("t0_word", wd, 107);
        check("t0_bit", bt, 28);
        check("t0_tf", tf, 1);

        // One full revolution between successive T0 pulses.
        cyc = 0; tfc = 0; badtf = 0; s = 0; found = 0;
        for (int i = 0; i < 13000; i++) begin
            tick();
            cyc++;
            if (ce) s++;
            if (tf) begin
                tfc++;
                if (wd[1:0] != 2'b11 || !t29) badtf++;
            end
            if (t0) begin found = 1; break; end
        end
        check("rev_t0_found", found, 1);
        check("rev_cycles", cyc, 12528);
        check("rev_strobes", s, 3132);
        check("rev_tf_count", tfc, 27);
        check("rev_tf_bad", badtf, 0);

        // Stop requested mid-word completes the word, then halts.
        found = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (bt == 5'd10 && wd == 7'd5) begin found = 1; break; end
        end
        check("stop_pos_found", found, 1);
        run = 1'b0;
        s = 0; last29 = 0; found = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (halted) begin found = 1; break; end
            if (ce) begin s++; last29 = t29; end
        end
        check("stop_halted", found, 1);
        check("stop_strobes", s, 19);
        check("stop_last_t29", last29, 1);
        check("stop_bit", bt, 29);
        check("stop_word", wd, 5);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (ce) n++;
        end
        check("stop_no_ce", n, 0);
        check("stop_still_halted", halted, 1);

`ifdef G15_TIMING_STEP_EN
        for (int k = 0; k < 3; k++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            c  = ce;
            k1 = (k == 0) ? t1 : (k == 1) ? t2 : (bt == 5'd2);
            h  = halted;
            n = 0;
            for (int i = 0; i < 4; i++) begin
                tick();
                if (ce) n++;
            end
            check("step_ce", c, 1);
            check("step_tn", k1, 1);
            check("step_halted_low", h, 0);
            check("step_single", n, 0);
        end
        check("step_end_halted", halted, 1);
`else
        n = 0;
        for (int k = 0; k < 3; k++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            if (ce) n++;
            for (int i = 0; i < 4; i++) begin
                tick();
                if (ce) n++;
            end
        end
        check("nostep_ce", n, 0);
        check("nostep_halted", halted, 1);
`endif
        check("step_bit", bt, B_STEP);
        check("step_word", wd, B_STEP == 29 ? 5 : 6);

        // RUN and STEP together: RUN wins, no immediate strobe.
        run = 1'b1; step = 1'b1;
        tick();
        step = 1'b0;
        check("runstep_halted", halted, 0);
        check("runstep_ce", ce, 0);
        n = 0;
        for (int i = 2; i <= 20; i++) begin
            tick();
            if (ce) begin n = i; break; end
        end
        check("runstep_first_ce", n, 4);
        tick();
        check("runstep_bit", bt, B_RUN1);
        check("runstep_word", wd, 6);

        // Stop request cancelled before T29.
        found = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (bt == 5'd10) begin found = 1; break; end
        end
        check("cancel_b10_found", found, 1);
        w = int'(wd);
        run = 1'b0;
        seen_halt = 0; found = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (halted) seen_halt = 1;
            if (bt == 5'd20) begin found = 1; break; end
        end
        check("cancel_b20_found", found, 1);
        run = 1'b1;
        found = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (halted) seen_halt = 1;
            if (int'(wd) == w + 1 && bt == 5'd5) begin found = 1; break; end
        end
        check("cancel_next_word", found, 1);
        check("cancel_no_halt", seen_halt, 0);

        // Asynchronous reset in the middle of a strobe cycle.
        found = 0;
        for (int i = 0; i < 8000; i++) begin
            tick();
            if (bt == 5'd15 && wd == 7'd60 && ce) begin found = 1; break; end
        end
        check("arst_pos_found", found, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_ce", ce, 0);
        check("arst_tpulse", tany(), 0);
        check("arst_bit", bt, 29);
        check("arst_word", wd, 107);
        check("arst_halted", halted, 1);
        run = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("arst_after_halted", halted, 1);

        // DIV=1: strobe every cycle, T0 once per 3132 cycles.
        run1 = 1'b1;
        tick();
        check("div1_first_ce", ce1, 1);
        check("div1_first_t1", t1_1, 1);
        cyc = 1; low = 0; found = 0;
        for (int i = 0; i < 4000; i++) begin
            tick();
            cyc++;
            if (!ce1) low++;
            if (t0_1) begin found = 1; break; end
        end
        check("div1_t0_found", found, 1);
        check("div1_t0_cycle", cyc, 3132);
        tick();
        check("div1_t0_single", t0_1, 0);
        check("div1_wrap_bit", bt1, 29);
        check("div1_wrap_word", wd1, 107);
        tick();
        check("div1_wrapped_word", wd1, 0);
        check("div1_wrapped_bit", bt1, 1);
        cyc = 2; found = 0;
        for (int i = 0; i < 4000; i++) begin
            tick();
            cyc++;
            if (!ce1) low++;
            if (t0_1) begin found = 1; break; end
        end
        check("div1_t0_again", found, 1);
        check("div1_t0_period", cyc, 3132);
        check("div1_ce_low", low, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
